serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single one-bit full-adder cell over two WIDTH-bit operands, one bit per clock, LSB first, with a registered carry between bits. It accepts a start pulse, reports busy, and pulses done when sum and carry-out are valid. It is the area-minimal alternative to a ripple-carry adder and is driven by a simple host or test sequencer.

---
 rtl/serial_adder_ctrl_pkg.sv | 18 +
 rtl/serial_adder_ctrl_if.sv | 36 +++
 rtl/serial_adder_ctrl_full_adder.sv | 19 +
 rtl/serial_adder_ctrl.sv | 127 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder controller.
//   state_e              : controller FSM states (2-bit encoding)
//   WIDTH_MIN/WIDTH_MAX  : legal range of the operand width parameter
// -----------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
// Host-side bus of the bit-serial adder controller.
//   start  : request an addition (host -> controller)
//   a, b   : WIDTH-bit operands (host -> controller)
//   cin    : carry-in (host -> controller)
//   busy   : bits being processed (controller -> host)
//   done   : one-cycle result-valid pulse (controller -> host)
//   sum    : WIDTH-bit result register (controller -> host)
//   cout   : final carry-out (controller -> host)
// master modport is the host/sequencer side, slave modport the controller.
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full-adder cell used as the single bit slice of the serial adder.
//   a_i, b_i, c_i : addend bits and carry-in
//   s_o           : sum bit
//   c_o           : carry-out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder controller: walks one full-adder cell over two WIDTH-bit
// operands, LSB first, one bit per clock, with a registered carry in between.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of serial_adder_ctrl_if (start/a/b/cin in,
//            busy/done/sum/cout out, all outputs registered)
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  bus
);

    // The bit counter needs at least one bit even when WIDTH is 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : gBadWidth
        $error("serial_adder_ctrl: WIDTH must be within 1..32");
    end

    state_e           state_q;
    logic [WIDTH-1:0] aSh_q;
    logic [WIDTH-1:0] bSh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             faSum;
    logic             faCarry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] aSh_d;
    logic [WIDTH-1:0] bSh_d;

    // The only arithmetic in the block: one full-adder fed by the LSBs of
    // the operand shifters and the carry left over from the previous bit.
    full_adder uFa (
        .a_i (aSh_q[0]),
        .b_i (bSh_q[0]),
        .c_i (carry_q),
        .s_o (faSum),
        .c_o (faCarry)
    );

    // Next-step shift values. Written as shift-then-overwrite-MSB so the
    // same code also works for WIDTH=1, where a concatenation with
    // sum_q[WIDTH-1:1] would be an empty slice.
    always_comb begin
        sum_d            = sum_q >> 1;
        sum_d[WIDTH-1]   = faSum;
        aSh_d            = aSh_q >> 1;
        bSh_d            = bSh_q >> 1;
    end

    // Controller FSM with registered outputs. busy/done are driven from
    // here directly so they are glitch-free and never high together.
    // cout only moves on the last RUN edge, so it keeps the previous
    // result visible for the whole of a new run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        aSh_q   <= bus.a;
                        bSh_q   <= bus.b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= faCarry;
                    aSh_q   <= aSh_d;
                    bSh_q   <= bSh_d;
                    if (cnt_q == CNT_LAST) begin
                        // Wrap the counter here so it never exceeds WIDTH-1.
                        cnt_q   <= '0;
                        cout_q  <= faCarry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl. Two instances are exercised:
// WIDTH=8 (dut8) and WIDTH=1 (dut1). A cycle-level behavioural model of each
// instance (phase counter + plain integer addition) is compared against the
// DUT outputs on every falling edge, and directed tests add literal checks.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int assertCount = 0;
    int failCount   = 0;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Model state per instance: phase 0 = idle, 1..w = processing bits,
    // w+1 = result-valid cycle. Results come from plain addition.
    int          phase   [2] = '{0, 0};
    logic [32:0] total   [2] = '{33'd0, 33'd0};
    logic [31:0] expSum  [2] = '{32'd0, 32'd0};
    logic        expCout [2] = '{1'b0, 1'b0};

    // Width-1 truth table of {cout,sum} indexed by {a,b,cin}.
    logic [1:0] truthTable [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    task automatic checkOutput(input string name, input logic [32:0] actual,
                               input logic [32:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input int k, input int w, input logic st,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic cin);
        if (phase[k] == 0) begin
            if (st) begin
                phase[k]  = 1;
                total[k]  = {1'b0, a} + {1'b0, b} + 33'(cin);
                expSum[k] = 32'd0;
            end
        end else if (phase[k] < w) begin
            phase[k]++;
        end else if (phase[k] == w) begin
            phase[k]   = w + 1;
            expSum[k]  = 32'(total[k] & ((33'd1 << w) - 33'd1));
            expCout[k] = total[k][w];
        end else begin
            phase[k] = 0;
        end
    endtask

    // Behavioural model advance, in step with the DUT clock and reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                phase[k]   = 0;
                total[k]   = 33'd0;
                expSum[k]  = 32'd0;
                expCout[k] = 1'b0;
            end
        end else begin
            modelStep(0, 8, bus8.start, 32'(bus8.a), 32'(bus8.b), bus8.cin);
            modelStep(1, 1, bus1.start, 32'(bus1.a), 32'(bus1.b), bus1.cin);
        end
    end

    // Per-cycle comparison of both instances against the model. sum is
    // intermediate while busy, so it is only compared outside RUN.
    always @(negedge clk) begin
        checkOutput("busy8", 33'(bus8.busy), 33'(phase[0] >= 1 && phase[0] <= 8));
        checkOutput("done8", 33'(bus8.done), 33'(phase[0] == 9));
        checkOutput("cout8", 33'(bus8.cout), 33'(expCout[0]));
        checkOutput("excl8", 33'(bus8.busy & bus8.done), 33'd0);
        if (!(phase[0] >= 1 && phase[0] <= 8))
            checkOutput("sum8", 33'(bus8.sum), 33'(expSum[0][7:0]));
        checkOutput("busy1", 33'(bus1.busy), 33'(phase[1] == 1));
        checkOutput("done1", 33'(bus1.done), 33'(phase[1] == 2));
        checkOutput("cout1", 33'(bus1.cout), 33'(expCout[1]));
        checkOutput("excl1", 33'(bus1.busy & bus1.done), 33'd0);
        if (phase[1] != 1)
            checkOutput("sum1", 33'(bus1.sum), 33'(expSum[1][0]));
    end

    function automatic logic doneOf(input int k);
        return (k == 0) ? bus8.done : bus1.done;
    endfunction

    task automatic driveBus(input int k, input logic st, input logic [31:0] a,
                            input logic [31:0] b, input logic cin);
        if (k == 0) begin
            bus8.start = st;
            bus8.a     = a[7:0];
            bus8.b     = b[7:0];
            bus8.cin   = cin;
        end else begin
            bus1.start = st;
            bus1.a     = a[0];
            bus1.b     = b[0];
            bus1.cin   = cin;
        end
    endtask

    // Issue one add at a falling edge, scramble operands after acceptance,
    // wait (bounded) for done and return the result seen with done plus the
    // latency in falling edges. Returns at a falling edge with the DUT idle.
    task automatic applyStimulus(input int k, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin,
                                 output logic [31:0] gotSum, output logic gotCout,
                                 output int lat);
        driveBus(k, 1'b1, a, b, cin);
        @(negedge clk);
        driveBus(k, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)));
        lat = 1;
        while (!doneOf(k) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("done_seen", 33'(doneOf(k)), 33'd1);
        gotSum  = (k == 0) ? 32'(bus8.sum) : 32'(bus1.sum);
        gotCout = (k == 0) ? bus8.cout : bus1.cout;
        @(negedge clk);
    endtask

    logic [31:0] gotSum;
    logic        gotCout;
    int          lat;
    int          doneCnt;
    logic [8:0]  expTotal;

    initial begin
        driveBus(0, 1'b0, 32'd0, 32'd0, 1'b0);
        driveBus(1, 1'b0, 32'd0, 32'd0, 1'b0);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 33'(bus8.busy), 33'd0);
        checkOutput("rst_done", 33'(bus8.done), 33'd0);
        checkOutput("rst_sum",  33'(bus8.sum),  33'd0);
        checkOutput("rst_cout", 33'(bus8.cout), 33'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add and latency.
        applyStimulus(0, 32'h5A, 32'h3C, 1'b0, gotSum, gotCout, lat);
        checkOutput("add5A3C_sum",  33'(gotSum),  33'h96);
        checkOutput("add5A3C_cout", 33'(gotCout), 33'd0);
        checkOutput("add5A3C_lat",  33'(lat),     33'd9);
        checkOutput("model_5A3C",   33'(expSum[0]), 33'h96);

        // Full carry propagation, from operand and from carry-in.
        applyStimulus(0, 32'hFF, 32'h01, 1'b0, gotSum, gotCout, lat);
        checkOutput("addFF01_sum",  33'(gotSum),  33'h00);
        checkOutput("addFF01_cout", 33'(gotCout), 33'd1);
        applyStimulus(0, 32'hFF, 32'h00, 1'b1, gotSum, gotCout, lat);
        checkOutput("addFF00c_sum",  33'(gotSum),  33'h00);
        checkOutput("addFF00c_cout", 33'(gotCout), 33'd1);
        checkOutput("model_FF00c",   33'({expCout[0], expSum[0][7:0]}), 33'h100);

        // start held high: one op per 10 cycles, mid-run operand changes
        // must not leak into the result.
        doneCnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (k > 0 && bus8.done) begin
                doneCnt++;
                checkOutput("cont_sum", 33'(bus8.sum), 33'h30);
            end
            if ((k % 10) >= 1 && (k % 10) <= 7)
                driveBus(0, 1'b1, 32'hFF, 32'hFF, 1'b0);
            else
                driveBus(0, 1'b1, 32'h10, 32'h20, 1'b0);
            @(negedge clk);
        end
        driveBus(0, 1'b0, 32'h0, 32'h0, 1'b0);
        checkOutput("cont_count", 33'(doneCnt), 33'd3);
        repeat (3) @(negedge clk);

        // Reset mid-run aborts with no done pulse.
        driveBus(0, 1'b1, 32'hAA, 32'h55, 1'b0);
        @(negedge clk);
        driveBus(0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 33'(bus8.busy), 33'd0);
        checkOutput("abort_sum",  33'(bus8.sum),  33'd0);
        checkOutput("abort_cout", 33'(bus8.cout), 33'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus8.done) doneCnt++;
        end
        checkOutput("abort_nodone", 33'(doneCnt), 33'd0);
        applyStimulus(0, 32'hAA, 32'h55, 1'b0, gotSum, gotCout, lat);
        checkOutput("postrst_sum",  33'(gotSum),  33'hFF);
        checkOutput("postrst_cout", 33'(gotCout), 33'd0);

        // WIDTH=1 truth table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 32'((i >> 2) & 1), 32'((i >> 1) & 1), 1'(i & 1),
                          gotSum, gotCout, lat);
            checkOutput($sformatf("w1_tt%0d", i), 33'({gotCout, gotSum[0]}),
                        33'(truthTable[i]));
            checkOutput($sformatf("w1_lat%0d", i), 33'(lat), 33'd2);
        end

        // Random operands on WIDTH=8 with random idle gaps.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            expTotal = {1'b0, ra} + {1'b0, rb} + 9'(rc);
            applyStimulus(0, 32'(ra), 32'(rb), rc, gotSum, gotCout, lat);
            checkOutput("rand_result", 33'({gotCout, gotSum[7:0]}), 33'(expTotal));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
